// File: rtl/pipeline_hazard_monitor_pkg.sv
// Shared constants for the pipeline hazard monitor: control-flow opcodes,
// check bit positions and the control-flow decode helper.
package pipeline_mon_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int unsigned CHK_FLUSH  = 0;
  localparam int unsigned CHK_STALL  = 1;
  localparam int unsigned CHK_LU     = 2;
  localparam int unsigned NUM_CHECKS = 3;

  function automatic logic is_ctrl_flow(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/pipeline_hazard_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module mon_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_monitor.sv
// Run-time checker for pipeline control: illegal flush, over-long stall runs
// and missing load-use stalls, reported as sticky flags, pulses and counters.
module pipeline_hazard_monitor
  import pipeline_mon_pkg::*;
#(
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned STALL_W   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [2:0]  CHECK_EN  = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic               stall,
  input  logic               flush,
  output logic [2:0]         err_flags,
  output logic [2:0]         err_pulse,
  output logic [CNT_W-1:0]   err_cnt_flush,
  output logic [CNT_W-1:0]   err_cnt_stall,
  output logic [CNT_W-1:0]   err_cnt_lu,
  output logic [STALL_W-1:0] stall_max
);

  logic [STALL_W-1:0]    w_run_len;
  logic [STALL_W-1:0]    w_run_inc;
  logic                  w_no_stall;
  logic [NUM_CHECKS-1:0] w_raw;
  logic [NUM_CHECKS-1:0] w_viol;

  logic [NUM_CHECKS-1:0] r_flags;
  logic [NUM_CHECKS-1:0] r_pulse;
  logic [STALL_W-1:0]    r_stall_max;

  assign w_no_stall = ~stall;

  // run_len holds the number of stall cycles preceding the current one
  mon_sat_counter #(.W(STALL_W)) u_run_len (
    .clk   (clk),
    .reset (reset),
    .clr   (w_no_stall),
    .inc   (stall),
    .cnt   (w_run_len)
  );

  assign w_run_inc = (w_run_len == '1) ? w_run_len : w_run_len + 1'b1;

  always_comb begin
    w_raw            = '0;
    w_raw[CHK_FLUSH] = flush && !is_ctrl_flow(opcode);
    // Equality (not >=) makes a long run fire once; saturation never re-hits it
    w_raw[CHK_STALL] = stall && (w_run_len == STALL_W'(MAX_STALL));
    w_raw[CHK_LU]    = ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == rs1) || (ex_rd == rs2)) && !stall && !flush;
  end

  assign w_viol = w_raw & CHECK_EN;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags     <= '0;
      r_pulse     <= '0;
      r_stall_max <= '0;
    end else begin
      r_flags <= r_flags | w_viol;
      r_pulse <= w_viol;
      if (stall && (w_run_inc > r_stall_max)) begin
        r_stall_max <= w_run_inc;
      end
    end
  end

  mon_sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_viol[CHK_FLUSH]),
    .cnt   (err_cnt_flush)
  );

  mon_sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_viol[CHK_STALL]),
    .cnt   (err_cnt_stall)
  );

  mon_sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_viol[CHK_LU]),
    .cnt   (err_cnt_lu)
  );

  assign err_flags = r_flags;
  assign err_pulse = r_pulse;
  assign stall_max = r_stall_max;

endmodule

// File: tb/tb_pipeline_hazard_monitor.sv
// Scoreboard bench for pipeline_hazard_monitor: three configurations share one
// stimulus stream; expected outputs are queued at drive time and popped after the edge.
module tb_pipeline_hazard_monitor;

  typedef struct packed {
    logic [2:0] flags;
    logic [2:0] pulse;
    logic [7:0] cf;
    logic [7:0] cs;
    logic [7:0] cl;
    logic [3:0] smax;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, ex_mem_read, stall, flush;
  logic [6:0] opcode;
  logic [4:0] ex_rd, rs1, rs2;

  logic [2:0] flags0, pulse0, flags1, pulse1, flags2, pulse2;
  logic [7:0] cf0, cs0, cl0, cf2, cs2, cl2;
  logic [1:0] cf1, cs1, cl1;
  logic [3:0] sm0, sm1, sm2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [3:0] m_run  = '0;
  logic [3:0] m_smax = '0;
  logic [2:0] m_flags [3];
  logic [2:0] m_pulse [3];
  logic [7:0] m_cnt   [3][3];
  logic [7:0] m_cmax  [3] = '{8'd255, 8'd3, 8'd255};
  logic [2:0] m_en    [3] = '{3'b111, 3'b111, 3'b010};

  always #5 clk = ~clk;

  pipeline_hazard_monitor u_dut_def (
    .clk(clk), .reset(reset), .opcode(opcode), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush),
    .err_flags(flags0), .err_pulse(pulse0), .err_cnt_flush(cf0),
    .err_cnt_stall(cs0), .err_cnt_lu(cl0), .stall_max(sm0)
  );

  pipeline_hazard_monitor #(.CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .reset(reset), .opcode(opcode), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush),
    .err_flags(flags1), .err_pulse(pulse1), .err_cnt_flush(cf1),
    .err_cnt_stall(cs1), .err_cnt_lu(cl1), .stall_max(sm1)
  );

  pipeline_hazard_monitor #(.CHECK_EN(3'b010)) u_dut_en010 (
    .clk(clk), .reset(reset), .opcode(opcode), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .rs1(rs1), .rs2(rs2), .stall(stall), .flush(flush),
    .err_flags(flags2), .err_pulse(pulse2), .err_cnt_flush(cf2),
    .err_cnt_stall(cs2), .err_cnt_lu(cl2), .stall_max(sm2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int unsigned i);
    exp_t e;
    e.flags = m_flags[i];
    e.pulse = m_pulse[i];
    e.cf    = m_cnt[i][0];
    e.cs    = m_cnt[i][1];
    e.cl    = m_cnt[i][2];
    e.smax  = m_smax;
    return e;
  endfunction

  task automatic model_step();
    logic [2:0] raw;
    logic [2:0] v;
    logic       cflow;
    logic [3:0] inc;
    if (reset) begin
      m_run  = '0;
      m_smax = '0;
      for (int i = 0; i < 3; i++) begin
        m_flags[i] = '0;
        m_pulse[i] = '0;
        for (int k = 0; k < 3; k++) m_cnt[i][k] = '0;
      end
    end else begin
      cflow  = (opcode == 7'b1100011) || (opcode == 7'b1101111) || (opcode == 7'b1100111);
      raw[0] = flush && !cflow;
      raw[1] = stall && (m_run == 4'd2);
      raw[2] = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2))
               && !stall && !flush;
      inc    = (m_run == 4'd15) ? 4'd15 : m_run + 4'd1;
      if (stall && (inc > m_smax)) m_smax = inc;
      m_run = stall ? inc : 4'd0;
      for (int i = 0; i < 3; i++) begin
        v          = raw & m_en[i];
        m_pulse[i] = v;
        m_flags[i] = m_flags[i] | v;
        for (int k = 0; k < 3; k++)
          if (v[k] && (m_cnt[i][k] < m_cmax[i])) m_cnt[i][k] = m_cnt[i][k] + 8'd1;
      end
    end
    q0.push_back(mk_exp(0));
    q1.push_back(mk_exp(1));
    q2.push_back(mk_exp(2));
  endtask

  task automatic compare_all();
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = q0.pop_front();
    check_val("d0_flags", 32'(flags0), 32'(e.flags));
    check_val("d0_pulse", 32'(pulse0), 32'(e.pulse));
    check_val("d0_cnt_flush", 32'(cf0), 32'(e.cf));
    check_val("d0_cnt_stall", 32'(cs0), 32'(e.cs));
    check_val("d0_cnt_lu", 32'(cl0), 32'(e.cl));
    check_val("d0_stall_max", 32'(sm0), 32'(e.smax));
    e = q1.pop_front();
    check_val("d1_flags", 32'(flags1), 32'(e.flags));
    check_val("d1_pulse", 32'(pulse1), 32'(e.pulse));
    check_val("d1_cnt_flush", 32'(cf1), 32'(e.cf));
    check_val("d1_cnt_stall", 32'(cs1), 32'(e.cs));
    check_val("d1_cnt_lu", 32'(cl1), 32'(e.cl));
    check_val("d1_stall_max", 32'(sm1), 32'(e.smax));
    e = q2.pop_front();
    check_val("d2_flags", 32'(flags2), 32'(e.flags));
    check_val("d2_pulse", 32'(pulse2), 32'(e.pulse));
    check_val("d2_cnt_flush", 32'(cf2), 32'(e.cf));
    check_val("d2_cnt_stall", 32'(cs2), 32'(e.cs));
    check_val("d2_cnt_lu", 32'(cl2), 32'(e.cl));
    check_val("d2_stall_max", 32'(sm2), 32'(e.smax));
  endtask

  task automatic cyc(input logic rst, input logic [6:0] op, input logic mr,
                     input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                     input logic st, input logic fl);
    reset       = rst;
    opcode      = op;
    ex_mem_read = mr;
    ex_rd       = rd;
    rs1         = a;
    rs2         = b;
    stall       = st;
    flush       = fl;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 7'b0010011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic stall_cyc();
    cyc(1'b0, 7'b0010011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [6:0] ops [5];
    ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0000011};

    cyc(1'b1, 7'b0110011, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    cyc(1'b1, 7'b0110011, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    check_val("tp_reset_flags", 32'(flags0), 32'd0);
    check_val("tp_reset_smax", 32'(sm0), 32'd0);
    idle();

    // illegal flush, then flushes on each control-flow opcode
    cyc(1'b0, 7'b0110011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check_val("tp_flush_pulse", 32'(pulse0), 32'b001);
    check_val("tp_flush_cnt", 32'(cf0), 32'd1);
    idle();
    check_val("tp_flush_pulse_end", 32'(pulse0), 32'd0);
    check_val("tp_flush_sticky", 32'(flags0), 32'b001);
    cyc(1'b0, 7'b1100011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(1'b0, 7'b1101111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(1'b0, 7'b1100111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check_val("tp_cf_flush_ok", 32'(cf0), 32'd1);

    // stall runs of 2 and 5
    stall_cyc(); stall_cyc(); idle();
    check_val("tp_stall2_cnt", 32'(cs0), 32'd0);
    check_val("tp_stall2_max", 32'(sm0), 32'd2);
    stall_cyc(); stall_cyc(); stall_cyc();
    check_val("tp_stall5_pulse", 32'(pulse0), 32'b010);
    stall_cyc();
    check_val("tp_stall5_once", 32'(pulse0), 32'd0);
    stall_cyc(); idle();
    check_val("tp_stall5_cnt", 32'(cs0), 32'd1);
    check_val("tp_stall5_max", 32'(sm0), 32'd5);

    // load-use: real hazard, x0 destination, already stalled
    cyc(1'b0, 7'b0000011, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    check_val("tp_lu_pulse", 32'(pulse0), 32'b100);
    cyc(1'b0, 7'b0000011, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check_val("tp_lu_x0", 32'(pulse0), 32'd0);
    cyc(1'b0, 7'b0000011, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0);
    check_val("tp_lu_stalled", 32'(pulse0), 32'd0);
    idle();

    // counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) cyc(1'b0, 7'b0110011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check_val("tp_sat_cnt", 32'(cf1), 32'd3);
    check_val("tp_sat_flag", 32'(flags1[0]), 32'd1);
    idle();

    // CHECK_EN=010: flush and load-use signals alongside a stall-length violation
    stall_cyc(); stall_cyc();
    cyc(1'b0, 7'b0110011, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1);
    check_val("tp_en_pulse", 32'(pulse2), 32'b010);
    idle();
    cyc(1'b0, 7'b0110011, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0);
    check_val("tp_en_lu_off", 32'(pulse2), 32'd0);
    check_val("tp_en_flags", 32'(flags2), 32'b010);

    // reset during 2nd stall cycle discards the run
    stall_cyc();
    cyc(1'b1, 7'b0010011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check_val("tp_rst_flags", 32'(flags0), 32'd0);
    check_val("tp_rst_cnt", 32'(cf0), 32'd0);
    check_val("tp_rst_max", 32'(sm0), 32'd0);
    stall_cyc(); stall_cyc(); idle();
    check_val("tp_rst_nostall", 32'(cs0), 32'd0);
    check_val("tp_rst_max2", 32'(sm0), 32'd2);

    // long run saturates run length and stall_max
    for (int i = 0; i < 20; i++) stall_cyc();
    idle();
    check_val("tp_long_max", 32'(sm0), 32'd15);
    check_val("tp_long_cnt", 32'(cs0), 32'd1);

    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          ops[$urandom_range(0, 4)],
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
